// File: rtl/memory_access_pkg.sv
// ============================================================================
// memory_access_pkg : shared state encodings and defaults for the MEM stage
// Rev 1.0
// ============================================================================
`default_nettype none

package memory_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10,
        ST_ERR    = 2'b11
    } state_t;

    localparam int unsigned DEFAULT_TIMEOUT = 16;

endpackage

`default_nettype wire

// File: rtl/access_timer.sv
// ============================================================================
// access_timer : clearable/enabled cycle counter with terminal-count compare
// Rev 1.0
// ============================================================================
`default_nettype none

module access_timer
    import memory_access_pkg::*;
#(
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired_o = (cnt_q == LAST_COUNT);

endmodule

`default_nettype wire

// File: rtl/memory_access_ctrl.sv
// ============================================================================
// memory_access_ctrl : MEM-stage handshake with multi-cycle data memory,
//                      pipeline stall generation and registered load data
// Rev 1.0
// ============================================================================
`default_nettype none

module memory_access_ctrl
    import memory_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [15:0] Addr_in,
    input  logic [15:0] WrData_in,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] mem_out,
    output logic        mem_stall,
    output logic        align_err,
    output logic        timeout_err
);

    state_t      state_q, state_d;
    logic        wr_q;
    logic [15:0] mem_out_q;

    logic        req;
    logic        in_idle;
    logic        issue;
    logic        capture;
    logic        timer_clr;
    logic        timer_en;
    logic        timer_expired;

    assign req     = MemRead_in | MemWrite_in;
    assign in_idle = (state_q == ST_IDLE);

    // Request-side decodes are gated by rst so outputs sit at reset values
    // even while EX/MEM keeps presenting a request during reset.
    assign issue     = rst & in_idle & req & ~Addr_in[0];
    assign align_err = rst & in_idle & req &  Addr_in[0];

    assign capture   = (state_q == ST_ACCESS) & mem_done & ~wr_q;
    assign timer_clr = issue;
    assign timer_en  = (state_q == ST_ACCESS) & ~mem_done;

    access_timer #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (issue) state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (mem_done) begin
                    state_d = ST_DONE;
                end else if (timer_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE:   state_d = ST_IDLE;
            ST_ERR:    state_d = ST_ERR;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            wr_q      <= 1'b0;
            mem_out_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (issue) begin
                wr_q <= MemWrite_in;
            end
            if (capture) begin
                mem_out_q <= mem_rdata;
            end
        end
    end

    assign mem_en      = issue;
    assign mem_wr      = issue & MemWrite_in;
    assign mem_addr    = Addr_in;
    assign mem_wdata   = WrData_in;
    assign mem_out     = mem_out_q;
    assign mem_stall   = issue | (state_q == ST_ACCESS) | (state_q == ST_ERR);
    assign timeout_err = (state_q == ST_ERR);

endmodule

`default_nettype wire

// File: tb/tb_memory_access_ctrl.sv
// ============================================================================
// tb_memory_access_ctrl : directed self-checking bench for memory_access_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_memory_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead_in;
    logic        MemWrite_in;
    logic [15:0] Addr_in;
    logic [15:0] WrData_in;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_out;
    logic        mem_stall;
    logic        align_err;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    memory_access_ctrl #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .MemRead_in  (MemRead_in),
        .MemWrite_in (MemWrite_in),
        .Addr_in     (Addr_in),
        .WrData_in   (WrData_in),
        .mem_done    (mem_done),
        .mem_rdata   (mem_rdata),
        .mem_en      (mem_en),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_out     (mem_out),
        .mem_stall   (mem_stall),
        .align_err   (align_err),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change just after a falling edge; outputs are sampled 1 time unit later.
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0;
        Addr_in = 16'h1234; WrData_in = 16'h0000; mem_done = 1'b0; mem_rdata = 16'h0000;

        // Reset state, including a request presented during reset
        cyc(); cyc();
        MemRead_in = 1'b1; Addr_in = 16'h1234;
        #1;
        chk("rst_mem_out",   mem_out,     16'h0000);
        chk("rst_mem_en",    mem_en,      16'h0);
        chk("rst_mem_wr",    mem_wr,      16'h0);
        chk("rst_stall",     mem_stall,   16'h0);
        chk("rst_align",     align_err,   16'h0);
        chk("rst_timeout",   timeout_err, 16'h0);
        chk("rst_addr_pass", mem_addr,    16'h1234);
        MemRead_in = 1'b0;

        // Load at 0x0040, mem_done two cycles after issue
        cyc(); rst = 1'b1;
        cyc(); MemRead_in = 1'b1; Addr_in = 16'h0040; #1;
        chk("ld_issue_en",    mem_en,    16'h1);
        chk("ld_issue_wr",    mem_wr,    16'h0);
        chk("ld_issue_stall", mem_stall, 16'h1);
        chk("ld_issue_addr",  mem_addr,  16'h0040);
        cyc(); #1;
        chk("ld_acc1_en",    mem_en,    16'h0);
        chk("ld_acc1_stall", mem_stall, 16'h1);
        cyc(); mem_done = 1'b1; mem_rdata = 16'hBEEF; #1;
        chk("ld_acc2_stall", mem_stall, 16'h1);
        chk("ld_acc2_out",   mem_out,   16'h0000);
        cyc(); mem_done = 1'b0; mem_rdata = 16'h0000; #1;
        chk("ld_done_stall", mem_stall, 16'h0);
        chk("ld_done_noreissue", mem_en, 16'h0);
        chk("ld_done_out",   mem_out,   16'hBEEF);
        MemRead_in = 1'b0;
        cyc(); #1;
        chk("ld_idle_stall", mem_stall, 16'h0);
        chk("ld_idle_out",   mem_out,   16'hBEEF);

        // Store at 0x0100, done one cycle after issue; mem_out untouched
        cyc(); MemWrite_in = 1'b1; Addr_in = 16'h0100; WrData_in = 16'h1234; #1;
        chk("st_issue_en",    mem_en,    16'h1);
        chk("st_issue_wr",    mem_wr,    16'h1);
        chk("st_issue_wdata", mem_wdata, 16'h1234);
        chk("st_issue_stall", mem_stall, 16'h1);
        cyc(); mem_done = 1'b1; mem_rdata = 16'h5555; #1;
        chk("st_acc_stall", mem_stall, 16'h1);
        chk("st_acc_en",    mem_en,    16'h0);
        cyc(); mem_done = 1'b0; #1;
        chk("st_done_stall", mem_stall, 16'h0);
        chk("st_done_out",   mem_out,   16'hBEEF);
        MemWrite_in = 1'b0;

        // Misaligned load at 0x0041
        cyc(); MemRead_in = 1'b1; Addr_in = 16'h0041; #1;
        chk("mis_align", align_err, 16'h1);
        chk("mis_en",    mem_en,    16'h0);
        chk("mis_stall", mem_stall, 16'h0);
        cyc(); MemRead_in = 1'b0; #1;
        chk("mis_align_clear", align_err, 16'h0);

        // Back-to-back loads; first issue also shows state stayed IDLE
        cyc(); MemRead_in = 1'b1; Addr_in = 16'h0040; #1;
        chk("b2b_issue1_en", mem_en, 16'h1);
        cyc(); mem_done = 1'b1; mem_rdata = 16'h1111; #1;
        chk("b2b_acc1_en", mem_en, 16'h0);
        cyc(); mem_done = 1'b0; Addr_in = 16'h0042; #1;
        chk("b2b_done1_en",  mem_en,  16'h0);
        chk("b2b_done1_out", mem_out, 16'h1111);
        cyc(); #1;
        chk("b2b_issue2_en",    mem_en,    16'h1);
        chk("b2b_issue2_stall", mem_stall, 16'h1);
        cyc(); mem_done = 1'b1; mem_rdata = 16'h2222; #1;
        chk("b2b_acc2_out", mem_out, 16'h1111);
        cyc(); mem_done = 1'b0; #1;
        chk("b2b_done2_out", mem_out, 16'h2222);
        MemRead_in = 1'b0;

        // Timeout with TIMEOUT_CYCLES=4
        cyc(); MemRead_in = 1'b1; Addr_in = 16'h0080; #1;
        chk("to_issue_en", mem_en, 16'h1);
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            chk("to_acc_stall",   mem_stall,   16'h1);
            chk("to_acc_timeout", timeout_err, 16'h0);
        end
        cyc(); #1;
        chk("to_err_flag",  timeout_err, 16'h1);
        chk("to_err_stall", mem_stall,   16'h1);
        cyc(); mem_done = 1'b1; mem_rdata = 16'h7777; #1;
        chk("to_err_sticky", timeout_err, 16'h1);
        cyc(); mem_done = 1'b0; #1;
        chk("to_err_sticky2", timeout_err, 16'h1);
        chk("to_err_out",     mem_out,     16'h2222);
        rst = 1'b0; #1;
        chk("to_rst_timeout", timeout_err, 16'h0);
        chk("to_rst_stall",   mem_stall,   16'h0);
        chk("to_rst_out",     mem_out,     16'h0000);
        MemRead_in = 1'b0;
        cyc(); rst = 1'b1;

        // Preload mem_out, then reset on the 2nd ACCESS cycle
        cyc(); MemRead_in = 1'b1; Addr_in = 16'h0010;
        cyc(); mem_done = 1'b1; mem_rdata = 16'hA5A5;
        cyc(); mem_done = 1'b0; #1;
        chk("rm_pre_out", mem_out, 16'hA5A5);
        cyc(); #1;
        chk("rm_issue_en", mem_en, 16'h1);
        cyc();
        cyc(); rst = 1'b0; #1;
        chk("rm_rst_out",   mem_out,     16'h0000);
        chk("rm_rst_stall", mem_stall,   16'h0);
        chk("rm_rst_en",    mem_en,      16'h0);
        chk("rm_rst_align", align_err,   16'h0);
        chk("rm_rst_to",    timeout_err, 16'h0);
        MemRead_in = 1'b0;
        cyc(); rst = 1'b1; mem_done = 1'b1; mem_rdata = 16'hDEAD; #1;
        chk("rm_late_stall", mem_stall, 16'h0);
        cyc(); mem_done = 1'b0; #1;
        chk("rm_late_out",   mem_out,   16'h0000);
        chk("rm_late_stall2", mem_stall, 16'h0);
        cyc(); MemRead_in = 1'b1; Addr_in = 16'h0020; #1;
        chk("rm_reissue_en", mem_en, 16'h1);
        cyc(); mem_done = 1'b1; mem_rdata = 16'h3C3C;
        cyc(); mem_done = 1'b0; MemRead_in = 1'b0; #1;
        chk("rm_reissue_out", mem_out, 16'h3C3C);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/memory_access_ctrl.md
# memory_access_ctrl

Memory-stage access controller for the 16-bit pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns a load or store from EX/MEM into a handshake with the multi-cycle data memory and stalls the upstream pipeline while the access is outstanding. It delivers registered load data on `mem_out`, which drives `mem_out_in` of the MEM/WB register.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: number of ACCESS cycles allowed without `mem_done` before a fatal timeout. Legal range 2..255.
- `CNT_W`, default 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- `clk` in 1: single clock. All state updates on its rising edge.
- `rst` in 1: reset. Asynchronous, active-low.
- `MemRead_in` in 1: load request, from EX/MEM.
- `MemWrite_in` in 1: store request, from EX/MEM.
- `Addr_in` in 16: byte address, from EX/MEM ALU result.
- `WrData_in` in 16: store data, from EX/MEM.
- `mem_done` in 1: data memory completion strobe, one cycle wide.
- `mem_rdata` in 16: data memory read data, valid only when `mem_done`=1.
- `mem_en` out 1: request strobe to data memory, one cycle wide.
- `mem_wr` out 1: 1 = write. Valid with `mem_en`.
- `mem_addr` out 16: equal to `Addr_in`, combinational.
- `mem_wdata` out 16: equal to `WrData_in`, combinational.
- `mem_out` out 16: registered load data, to MEM/WB `mem_out_in`.
- `mem_stall` out 1: freezes PC, IF/ID, ID/EX and EX/MEM, and forces a bubble (`RegWrite_in`=0) into MEM/WB.
- `align_err` out 1: one-cycle pulse for a misaligned access.
- `timeout_err` out 1: sticky fatal error.

## Operation
- States: IDLE, ACCESS, DONE, ERR.
- `req` = `MemRead_in` | `MemWrite_in`. If both are high, the access is a write (`mem_wr`=1).
- **IDLE**
  - If `req` and `Addr_in[0]`=0: `mem_en`=1, `mem_stall`=1 (both combinational), counter cleared, next state ACCESS.
  - If `req` and `Addr_in[0]`=1: `align_err`=1 for this cycle only, no `mem_en`, no stall, stay in IDLE.
  - `mem_done` is ignored in IDLE.
- **ACCESS**
  - `mem_stall`=1, `mem_en`=0.
  - On `mem_done`: if the access is a read, `mem_out` <= `mem_rdata`; next state DONE.
  - Otherwise the counter increments. When the counter equals `TIMEOUT_CYCLES`-1 and `mem_done`=0, next state is ERR.
  - `mem_done` wins over timeout in the same cycle.
- **DONE**
  - `mem_stall`=0 and `mem_en`=0. The frozen instruction advances into MEM/WB on this cycle's closing edge.
  - Next state is IDLE unconditionally. The still-asserted `req` is not reissued in this cycle.
- **ERR**
  - `mem_stall`=1 and `timeout_err`=1 permanently. Exit only by reset.
- `mem_out` holds its last value outside the DONE-capture edge. Stores never modify `mem_out`.
- The read/write type is latched at issue (`wr_q`). Changes on `MemRead_in`/`MemWrite_in` during ACCESS are ignored; EX/MEM is frozen anyway.

## Timing
- Minimum access occupancy is 3 cycles: issue at T (IDLE), `mem_done` at T+1 (ACCESS), release at T+2 (DONE).
- A memory latency of L cycles after issue gives L+1 stall cycles.
- Back-to-back memory instructions: the second instruction issues in the IDLE cycle immediately after DONE. Accesses are never pipelined.
- Reset (`rst`=0, any time, including mid-ACCESS):
  - state forced to IDLE, counter 0, `wr_q` 0.
  - outputs: `mem_out`=16'h0000, `mem_en`=0, `mem_wr`=0, `mem_stall`=0, `align_err`=0, `timeout_err`=0.
  - `mem_addr` and `mem_wdata` remain combinational pass-throughs of their inputs.
  - An outstanding memory request is abandoned. A `mem_done` arriving after reset release while in IDLE is ignored.
- Timeout: ERR is entered on the edge after `TIMEOUT_CYCLES` consecutive ACCESS cycles without `mem_done`.

## Structure
- Package `memory_access_pkg` holds:
  - state encodings: IDLE=2'b00, ACCESS=2'b01, DONE=2'b10, ERR=2'b11.
  - the default timeout constant, 16.
- Sub-module `access_timer`: a `CNT_W`-bit counter with clear, enable and an `expired` compare output.
- All state flops use asynchronous active-low reset. The codebase `dff` cell is not reused, because its reset is synchronous.

## Test plan
- Load at `Addr_in`=16'h0040, `mem_done` 2 cycles after issue with `mem_rdata`=16'hBEEF -> `mem_en` pulses once with `mem_wr`=0, `mem_stall` high for exactly 3 cycles, `mem_out`=16'hBEEF from the DONE cycle on.
- Store at 16'h0100 with `WrData_in`=16'h1234, done after 1 cycle -> `mem_en`=1 and `mem_wr`=1 for one cycle, `mem_wdata`=16'h1234, stall for 2 cycles, `mem_out` unchanged.
- Load at 16'h0041 -> `align_err` high for 1 cycle, `mem_en`=0, `mem_stall`=0, state stays IDLE.
- `TIMEOUT_CYCLES`=4, `mem_done` never asserted -> ERR after 4 ACCESS cycles, `timeout_err`=1 and `mem_stall`=1 held until `rst`=0.
- `rst` asserted on the 2nd ACCESS cycle, then a late `mem_done` -> all outputs at reset values, and the late `mem_done` causes no capture and no state change.
- Two back-to-back loads -> second `mem_en` occurs exactly one cycle after the first DONE cycle, and each `mem_out` value matches its own `mem_rdata`.
